// File: rtl/config_loader_pkg.sv
// config_loader_pkg: load-sequencer states and readback marker shared by config_chain_loader
package config_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MARKER,
        ST_FETCH,
        ST_SHIFT,
        ST_DONE
    } state_t;

    localparam int MARKER_WIDTH = 16;
    localparam logic [MARKER_WIDTH-1:0] MARKER = 16'hA5C3;

endpackage

// File: rtl/config_loader_serializer.sv
// config_loader_serializer: latches one bitstream word and hands its bits out LSB-first,
// one bit ahead of the chain so the top can register chain_data without extra latency.
module config_loader_serializer #(
    parameter int WORD_WIDTH = 32,
    localparam int CW = $clog2(WORD_WIDTH + 1)
) (
    input  logic                  config_clock,
    input  logic                  config_nreset,
    input  logic                  load,
    input  logic [WORD_WIDTH-1:0] word,
    input  logic [CW-1:0]         nbits,
    input  logic                  shift,
    output logic                  bit_out,
    output logic                  word_done
);

    logic [WORD_WIDTH-1:0] r_sreg;
    logic [CW-1:0]         r_cnt;

    // bit 0 goes straight to chain_data at load, so the register keeps bits 1.. and the count of bits still owed
    always_ff @(posedge config_clock or negedge config_nreset) begin
        if (!config_nreset) begin
            r_sreg <= '0;
            r_cnt  <= '0;
        end else if (load) begin
            r_sreg <= word >> 1;
            r_cnt  <= nbits;
        end else if (shift && r_cnt != '0) begin
            r_sreg <= r_sreg >> 1;
            r_cnt  <= r_cnt - CW'(1);
        end
    end

    assign bit_out   = r_sreg[0];
    assign word_done = (r_cnt == CW'(1));

endmodule

// File: rtl/config_chain_loader.sv
// config_chain_loader: serializes host bitstream words LSB-first into the tile config chain.
// Optional readback check of a 16-bit marker at the chain tail: define CONFIG_LOADER_READBACK_EN
// (assumes CHAIN_LENGTH >= 16 so the whole marker returns during payload shifts).
module config_chain_loader
    import config_loader_pkg::*;
#(
    parameter int WORD_WIDTH   = 32,
    parameter int CHAIN_LENGTH = 2304
) (
    input  logic                  config_clock,
    input  logic                  config_nreset,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] word_data,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  chain_data,
    output logic                  chain_enable,
    input  logic                  chain_return,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int RW     = $clog2(CHAIN_LENGTH + 1);
    localparam int CW     = $clog2(WORD_WIDTH + 1);
    localparam int WW_CAP = (WORD_WIDTH < CHAIN_LENGTH) ? WORD_WIDTH : CHAIN_LENGTH;

    state_t        r_state;
    logic [RW-1:0] r_rem;
    logic          r_ready;
    logic          r_data;
    logic          r_enable;
    logic          r_busy;
    logic          r_done;
    logic          w_load;
    logic          w_shift;
    logic          w_bit_out;
    logic          w_word_done;
    logic [CW-1:0] w_nbits;

    assign w_load  = (r_state == ST_FETCH) && word_valid;
    assign w_shift = (r_state == ST_SHIFT);
    // the last word only carries the bits still owed to the chain; its high bits are dropped
    assign w_nbits = (r_rem >= RW'(WW_CAP)) ? CW'(WW_CAP) : CW'(r_rem);

`ifdef CONFIG_LOADER_READBACK_EN
    logic [3:0] r_mcnt;
    logic       r_error;
    logic [3:0] w_ridx;
    logic       w_mismatch;
    // the marker reaches the tail during the final 16 payload shifts: remaining r maps to marker bit 16-r
    assign w_ridx     = 4'(MARKER_WIDTH - 1) - 4'(r_rem - RW'(1));
    assign w_mismatch = (r_rem <= RW'(MARKER_WIDTH)) && (chain_return != MARKER[w_ridx]);
    assign error      = r_error;
`else
    logic w_unused_return;
    assign w_unused_return = chain_return;
    assign error           = 1'b0;
`endif

    config_loader_serializer #(
        .WORD_WIDTH(WORD_WIDTH)
    ) u_ser (
        .config_clock (config_clock),
        .config_nreset(config_nreset),
        .load         (w_load),
        .word         (word_data),
        .nbits        (w_nbits),
        .shift        (w_shift),
        .bit_out      (w_bit_out),
        .word_done    (w_word_done)
    );

    // load sequencer: IDLE -> [MARKER] -> (FETCH -> SHIFT)* -> DONE, every output set one edge ahead
    always_ff @(posedge config_clock or negedge config_nreset) begin
        if (!config_nreset) begin
            r_state  <= ST_IDLE;
            r_rem    <= '0;
            r_ready  <= 1'b0;
            r_data   <= 1'b0;
            r_enable <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef CONFIG_LOADER_READBACK_EN
            r_mcnt   <= '0;
            r_error  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        r_rem  <= RW'(CHAIN_LENGTH);
`ifdef CONFIG_LOADER_READBACK_EN
                        r_error  <= 1'b0;
                        r_mcnt   <= '0;
                        r_enable <= 1'b1;
                        r_data   <= MARKER[0];
                        r_state  <= ST_MARKER;
`else
                        r_ready <= 1'b1;
                        r_state <= ST_FETCH;
`endif
                    end
                end
`ifdef CONFIG_LOADER_READBACK_EN
                ST_MARKER: begin
                    if (r_mcnt == 4'(MARKER_WIDTH - 1)) begin
                        r_enable <= 1'b0;
                        r_ready  <= 1'b1;
                        r_state  <= ST_FETCH;
                    end else begin
                        r_data <= MARKER[r_mcnt + 4'd1];
                        r_mcnt <= r_mcnt + 4'd1;
                    end
                end
`endif
                ST_FETCH: begin
                    if (word_valid) begin
                        r_ready  <= 1'b0;
                        r_enable <= 1'b1;
                        r_data   <= word_data[0];
                        r_state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_rem <= r_rem - RW'(1);
`ifdef CONFIG_LOADER_READBACK_EN
                    if (w_mismatch) r_error <= 1'b1;
`endif
                    if (w_word_done) begin
                        r_enable <= 1'b0;
                        if (r_rem == RW'(1)) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_ready <= 1'b1;
                            r_state <= ST_FETCH;
                        end
                    end else begin
                        r_data <= w_bit_out;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign word_ready   = r_ready;
    assign chain_data   = r_data;
    assign chain_enable = r_enable;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule

// File: tb/tb_config_chain_loader.sv
// tb_config_chain_loader: randomized directed bench for config_chain_loader; expectations follow
// CONFIG_LOADER_READBACK_EN when it is defined for the build.
module tb_config_chain_loader;

    localparam int CL_A = 36, WW_A = 8, NW_A = 5;
    localparam int CL_B = 32, WW_B = 8, NW_B = 4;
`ifdef CONFIG_LOADER_READBACK_EN
    localparam int EXTRA = 16;
`else
    localparam int EXTRA = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            start_a = 1'b0, valid_a = 1'b0, flip_a = 1'b0;
    logic [WW_A-1:0] wdata_a = '0;
    logic            ready_a, data_a, en_a, ret_a, busy_a, done_a, err_a;
    logic [CL_A-1:0] model_a = '0;
    logic [WW_A-1:0] words_a [NW_A];

    logic            start_b = 1'b0, valid_b = 1'b0;
    logic [WW_B-1:0] wdata_b = '0;
    logic            ready_b, data_b, en_b, ret_b, busy_b, done_b, err_b;
    logic [CL_B-1:0] model_b = '0;
    logic [WW_B-1:0] words_b [NW_B];

    assign ret_a = model_a[CL_A-1] ^ flip_a;
    assign ret_b = model_b[CL_B-1];

    config_chain_loader #(.WORD_WIDTH(WW_A), .CHAIN_LENGTH(CL_A)) dut_a (
        .config_clock(clk), .config_nreset(rst_n), .start(start_a),
        .word_data(wdata_a), .word_valid(valid_a), .word_ready(ready_a),
        .chain_data(data_a), .chain_enable(en_a), .chain_return(ret_a),
        .busy(busy_a), .done(done_a), .error(err_a)
    );

    config_chain_loader #(.WORD_WIDTH(WW_B), .CHAIN_LENGTH(CL_B)) dut_b (
        .config_clock(clk), .config_nreset(rst_n), .start(start_b),
        .word_data(wdata_b), .word_valid(valid_b), .word_ready(ready_b),
        .chain_data(data_b), .chain_enable(en_b), .chain_return(ret_b),
        .busy(busy_b), .done(done_b), .error(err_b)
    );

    int cyc = 0;
    int sh_a = 0, dn_a = 0, hs_a = 0, last_sh_a = 0, dn_cyc_a = 0, st_cyc_a = 0;
    int sh_b = 0, dn_b = 0, hs_b = 0, rdy_b = 0, dn_cyc_b = 0, st_cyc_b = 0;

    // tile chains plus event counters, observed at every clock edge
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (en_a) begin
            model_a   <= {model_a[CL_A-2:0], data_a};
            sh_a      <= sh_a + 1;
            last_sh_a <= cyc;
        end
        if (done_a) begin
            dn_a     <= dn_a + 1;
            dn_cyc_a <= cyc;
        end
        if (valid_a && ready_a) hs_a <= hs_a + 1;
        if (start_a && !busy_a) st_cyc_a <= cyc;
        if (en_b) begin
            model_b <= {model_b[CL_B-2:0], data_b};
            sh_b    <= sh_b + 1;
        end
        if (done_b) begin
            dn_b     <= dn_b + 1;
            dn_cyc_b <= cyc;
        end
        if (valid_b && ready_b) hs_b <= hs_b + 1;
        if (ready_b) rdy_b <= rdy_b + 1;
        if (start_b && !busy_b) st_cyc_b <= cyc;
    end

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // payload bit p (word p/W, bit p%W) must finish in flop CL-1-p; flop CL-1 is the deepest
    function automatic logic [CL_A-1:0] exp_a();
        logic [CL_A-1:0] e;
        for (int p = 0; p < CL_A; p++) e[CL_A-1-p] = words_a[p / WW_A][p % WW_A];
        return e;
    endfunction

    function automatic logic [CL_B-1:0] exp_b();
        logic [CL_B-1:0] e;
        for (int p = 0; p < CL_B; p++) e[CL_B-1-p] = words_b[p / WW_B][p % WW_B];
        return e;
    endfunction

    task automatic rand_words_a();
        for (int i = 0; i < NW_A; i++) words_a[i] = WW_A'($urandom);
    endtask

    // one full host transaction on DUT A with optional stall, stray starts, or mid-load reset
    task automatic load_a(input int stall_at, input int stall_len, input bit poke,
                          input int rst_hs, input bit exp_err);
        int  sh0, dn0, hs0, st, k;
        bit  poked;
        sh0 = sh_a; dn0 = dn_a; hs0 = hs_a; st = 0; poked = 0;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        chk("busy_after_start", busy_a, 1);
        chk("error_cleared_by_start", err_a, 0);
        for (int c = 0; c < 2000 && !done_a; c++) begin
            k = hs_a - hs0;
            if (rst_hs >= 0 && k == rst_hs && en_a) begin
                rst_n   = 1'b0;
                valid_a = 1'b0;
                start_a = 1'b0;
                return;
            end
            if (k == stall_at && st < stall_len) begin
                valid_a = 1'b0;
                if (ready_a) begin
                    chk("stall_enable_low", en_a, 0);
                    st++;
                end
            end else begin
                valid_a = (k < NW_A);
                wdata_a = words_a[k < NW_A ? k : 0];
            end
            start_a = poke && !poked && k == 2 && en_a;
            if (start_a) poked = 1;
            @(negedge clk);
        end
        valid_a = 1'b0;
        chk("done_high", done_a, 1);
        chk("shift_count", sh_a - sh0, CL_A + EXTRA);
        chk("handshakes", hs_a - hs0, NW_A);
        chk("chain_contents", model_a, exp_a());
        chk("error_at_done", err_a, exp_err);
        if (poke) start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        chk("done_one_cycle", done_a, 0);
        chk("done_count", dn_a - dn0, 1);
        chk("done_after_last_shift", dn_cyc_a - last_sh_a, 1);
        if (stall_len == 0) chk("load_cycles", dn_cyc_a - st_cyc_a, NW_A + CL_A + 1 + EXTRA);
        repeat (6) @(negedge clk);
        chk("idle_busy", busy_a, 0);
        chk("idle_ready", ready_a, 0);
        chk("no_second_load", sh_a - sh0, CL_A + EXTRA);
        chk("single_done", dn_a - dn0, 1);
        chk("error_sticky", err_a, exp_err);
    endtask

    initial begin
        int sh0, hs0, rd0, k;
        words_a = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        repeat (3) @(negedge clk);
        chk("reset_outputs_a", {ready_a, data_a, en_a, busy_a, done_a, err_a}, 0);
        chk("reset_outputs_b", {ready_b, data_b, en_b, busy_b, done_b, err_b}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        load_a(-1, 0, 0, -1, 0);
        load_a(2, 10, 0, -1, 0);
        rand_words_a();
        load_a(-1, 0, 1, -1, 0);
        repeat (3) begin
            rand_words_a();
            load_a(int'($urandom_range(0, 4)), int'($urandom_range(0, 5)), 0, -1, 0);
        end

        rand_words_a();
        load_a(-1, 0, 0, 2, 0);
        #1;
        chk("reset_midload_outputs", {ready_a, data_a, en_a, busy_a, done_a, err_a}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rand_words_a();
        load_a(-1, 0, 0, -1, 0);

`ifdef CONFIG_LOADER_READBACK_EN
        flip_a = 1'b1;
        rand_words_a();
        load_a(-1, 0, 0, -1, 1);
        flip_a = 1'b0;
        load_a(-1, 0, 0, -1, 0);
`endif

        for (int i = 0; i < NW_B; i++) words_b[i] = WW_B'($urandom);
        sh0 = sh_b; hs0 = hs_b; rd0 = rdy_b;
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int c = 0; c < 2000 && !done_b; c++) begin
            k = hs_b - hs0;
            valid_b = (k < NW_B);
            wdata_b = words_b[k < NW_B ? k : 0];
            @(negedge clk);
        end
        valid_b = 1'b0;
        chk("b_done_high", done_b, 1);
        chk("b_shift_count", sh_b - sh0, CL_B + EXTRA);
        chk("b_handshakes", hs_b - hs0, NW_B);
        chk("b_chain_contents", model_b, exp_b());
        @(negedge clk);
        chk("b_load_cycles", dn_cyc_b - st_cyc_b, NW_B + CL_B + 1 + EXTRA);
        repeat (4) @(negedge clk);
        chk("b_fetch_cycles", rdy_b - rd0, NW_B);
        chk("b_idle_busy", busy_b, 0);
        chk("b_error", err_b, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
